// File: rtl/instr_queue_if.sv
// Fetch/decode-side handshake for the instruction queue.
// The master is the pipeline side (fetch pushes, decode pops); the slave is the queue.
interface instr_queue_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30
);
  logic                     flush;
  logic                     push;
  logic [WIDTH-1:0]         instrIn;
  logic                     queueFull;
  logic                     pop;
  logic                     queueEmpty;
  logic [31:0]              instrOut;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output flush, push, instrIn, pop,
    input  queueFull, queueEmpty, instrOut, count, overflow
  );

  modport slave (
    input  flush, push, instrIn, pop,
    output queueFull, queueEmpty, instrOut, count, overflow
  );
endinterface

// File: rtl/instr_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// Pointers carry an extra wrap bit so full and empty are told apart without a separate counter.
module instr_queue #(
  parameter int          DEPTH = 8,
  parameter int          WIDTH = 30,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic         clockGate,
  input  logic         resetn,
  instr_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic             overflowQ;
  logic             isEmpty;
  logic             isFull;
  logic             pushAccept;
  logic             popAccept;

  // Flags come from the registered pointers only, so push/pop never reach them combinationally.
  assign isEmpty = (rdPtr == wrPtr);
  assign isFull  = (rdPtr[AW-1:0] == wrPtr[AW-1:0]) && (rdPtr[AW] != wrPtr[AW]);

  assign pushAccept = bus.push && !isFull  && !bus.flush;
  assign popAccept  = bus.pop  && !isEmpty && !bus.flush;

  // NOTE: the storage array has no reset; only the pointers define which entries are valid,
  // so resetting data would only cost reset fan-out.
  always_ff @(posedge clockGate) begin
    if (pushAccept) begin
      mem[wrPtr[AW-1:0]] <= bus.instrIn;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clockGate or negedge resetn) begin
    if (!resetn) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      overflowQ <= 1'b0;
    end else if (bus.flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (pushAccept) wrPtr <= wrPtr + PW'(1);
      if (popAccept)  rdPtr <= rdPtr + PW'(1);
      if (bus.push && isFull) overflowQ <= 1'b1;
    end
  end

  assign bus.queueEmpty = isEmpty;
  assign bus.queueFull  = isFull;
  assign bus.count      = wrPtr - rdPtr;
  assign bus.overflow   = overflowQ;
  assign bus.instrOut   = isEmpty ? NOP : 32'({mem[rdPtr[AW-1:0]], 2'b11});
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- FIFO between the instruction fetch stage and decode.
- Accepts 30-bit fetched instruction words (instr[31:2]) on push and reports queueFull back to fetch.
- Presents the head entry first-word-fall-through to decode as a full 32-bit instruction with bits [1:0] = 2'b11.
- Cleared on pipeline redirect, so no wrong-path instruction survives a misprediction or interrupt.

Parameters:
- DEPTH, 8: number of entries; power of two, >= 2.
- WIDTH, 30: stored instruction bits (instr[31:2]).
- NOP, 32'h00000013: value driven on instrOut while empty.

Ports:
- clockGate  input  1  queue clock.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  redirect; discard all entries.
- push  input  1  write request from fetch.
- instrIn  input  WIDTH  instruction bits [31:2] from fetch.
- queueFull  output  1  no free entry.
- pop  input  1  decode consumes head entry.
- queueEmpty  output  1  no valid entry.
- instrOut  output  32  {head entry, 2'b11}; NOP when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- overflow  output  1  sticky: push attempted while full.

Behaviour:
- Storage: DEPTH x WIDTH array, not reset. rdPtr and wrPtr are $clog2(DEPTH)+1 bits; index uses the low bits, and the MSB is the wrap bit.
- queueEmpty = (rdPtr == wrPtr).
- queueFull = index bits equal and wrap bits differ.
- count = wrPtr - rdPtr, modulo 2^($clog2(DEPTH)+1).
- All flags derive from registered pointers only; no combinational path from push/pop to flags.
- Reset (async, resetn low): rdPtr = wrPtr = 0, overflow = 0.
  - Outputs at reset: queueEmpty = 1, queueFull = 0, count = 0, instrOut = NOP.
  - Reset mid-operation drops all entries immediately.
- Push accepted = push & ~queueFull & ~flush. On accept: mem[wrPtr] <= instrIn, wrPtr++ (wraps naturally).
- Pop accepted = pop & ~queueEmpty & ~flush. On accept: rdPtr++.
- Push while full (no flush): data dropped, pointers unchanged, overflow <= 1 and stays 1 until reset.
- Pop while empty: ignored, no error.
- Simultaneous push and pop:
  - Not full and not empty: both accepted, count unchanged.
  - Full: pop accepted, push rejected (flag sampled pre-edge), overflow set; next cycle count = DEPTH-1.
  - Empty: push accepted, pop ignored; entry visible next cycle.
- Latency: an accepted push is visible on instrOut and clears queueEmpty one clockGate edge later. No same-cycle bypass.
- instrOut = queueEmpty ? NOP : {mem[rdPtr index], 2'b11}. Combinational read of the registered head.
- Flush (synchronous): rdPtr <= 0, wrPtr <= 0.
  - Takes priority over push and pop in the same cycle; both are discarded.
  - overflow unchanged.
  - queueEmpty = 1 the following cycle.
- Wrap-around: pointers cycle past DEPTH indefinitely; full/empty stay correct across any number of wraps.

Test Plan:
- DEPTH=4, after reset -> queueEmpty=1, queueFull=0, count=0, instrOut=32'h00000013, overflow=0.
- Push A=30'h0000_0100, B=30'h0000_0200 on consecutive cycles, then pop twice:
  - instrOut = 32'h00000403 one cycle after A is pushed.
  - instrOut = 32'h00000803 after the first pop.
  - After the second pop, queueEmpty=1 and instrOut=NOP.
- Push 4 entries -> queueFull=1, count=4.
  - 5th push -> dropped, overflow=1, count stays 4.
  - Then push+pop together -> count=3, queueFull=0.
- Empty queue, push+pop same cycle -> count=1, instrOut=pushed value next cycle.
- 3 entries queued, flush+push+pop same cycle -> next cycle count=0, queueEmpty=1, pushed data absent.
- 10 push/pop pairs with distinct values in a 4-entry queue (pointer wrap) -> output order matches input order exactly; no spurious full/empty.
